// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - two-read one-write register file with zero register and write bypass
// Top index has no storage and reads as zero; reads see a same-cycle write through the bypass.
module reg_file_2r1w #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RegWrite,
   input  logic [AW-1:0]    WriteRegister,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [AW-1:0]    ReadRegister1,
   input  logic [AW-1:0]    ReadRegister2,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2
);

   localparam logic [AW-1:0] ZERO_REG = AW'(DEPTH - 1);

   logic [WIDTH-1:0] regs_q [DEPTH-1];
   logic [WIDTH-1:0] regs_d [DEPTH-1];
   logic             bypass1;
   logic             bypass2;

   // An X on RegWrite or the address falls to the hold branch, so unaddressed entries keep their value.
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (RegWrite && (WriteRegister == AW'(i))) begin
            regs_d[i] = WriteData;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign bypass1 = RegWrite && (WriteRegister == ReadRegister1);
   assign bypass2 = RegWrite && (WriteRegister == ReadRegister2);

   always_comb begin
      if (ReadRegister1 == ZERO_REG) begin
         ReadData1 = '0;
      end else if (bypass1) begin
         ReadData1 = WriteData;
      end else begin
         ReadData1 = regs_q[ReadRegister1];
      end
   end

   always_comb begin
      if (ReadRegister2 == ZERO_REG) begin
         ReadData2 = '0;
      end else if (bypass2) begin
         ReadData2 = WriteData;
      end else begin
         ReadData2 = regs_q[ReadRegister2];
      end
   end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Architectural register file for the ARM datapath: DEPTH words of WIDTH bits, one synchronous write port and two combinational read ports. It is the read-side counterpart to the plain DFF register banks. It supplies operands to decode and execute, and it accepts results from writeback. The top index is the zero register: it reads as 0 and ignores writes. A same-cycle write-to-read bypass lets decode observe a result being written back in that cycle.

## Interface
- WIDTH, 64, data width of each register.
- DEPTH, 32, number of registers. Must be a power of two, ≥ 2.
- AW, $clog2(DEPTH), address width. Derived; do not override.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  AW  write address.
- WriteData  input  WIDTH  write data.
- ReadRegister1  input  AW  read port 1 address.
- ReadRegister2  input  AW  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data (combinational).
- ReadData2  output  WIDTH  read port 2 data (combinational).

## Operation
- Storage: DEPTH-1 WIDTH-bit registers, indices 0..DEPTH-2. Index DEPTH-1 (X31/XZR for the default parameters) has no storage.
- Write: on the rising clk edge with RegWrite=1 and WriteRegister≠DEPTH-1, reg[WriteRegister] ← WriteData. Otherwise no register changes.
- A write to DEPTH-1 is silently dropped. No error indication.
- Read, per port n independently:
  - If ReadRegistern = DEPTH-1, ReadDatan = 0.
  - Else if RegWrite=1 and WriteRegister = ReadRegistern, ReadDatan = WriteData (bypass).
  - Else ReadDatan = reg[ReadRegistern].
- Both ports may address the same register. Both then return identical data, including the bypass case.
- Any X/Z on RegWrite or address inputs must not corrupt unaddressed registers.
- Reset: while reset=0, all stored registers are forced to 0 asynchronously. Writes are blocked for the whole time reset is low.
  - ReadDatan during reset follows the read rules above. With RegWrite=1 the bypass still drives WriteData; otherwise the output is 0.
- No state machine. The state is the register array only.

## Timing
- Write latency: 1 edge. Data presented in cycle N is visible from storage in cycle N+1.
- Bypass makes write data visible on the read port in cycle N itself, with combinational delay only.
- Read path is combinational: address mux → bypass compare → zero-register override. No clock is involved.
- Reset assertion takes effect immediately, without waiting for clk.
- On reset deassertion, the first write occurs on the first rising edge at which reset=1 and RegWrite=1.
- If reset rises coincident with a clk edge, that edge performs no write.
- Reset value of outputs: 0 for every address, unless bypass is active as described above.
- Simultaneous read and write of the same address in one cycle returns the new value (bypass), never the old value.
- Writes to different addresses on consecutive cycles are independent. There is no hazard beyond the bypass.

## Test plan
- Reset fill: write 64'hA5A5_A5A5_A5A5_A5A5 to X0..X30. Assert reset=0 mid-cycle, between edges. Read all 32 addresses → 0 immediately, before the next edge, and after the reset is released.
- Write/readback: write X5 ← 64'h1234, then X6 ← 64'hFFFF_FFFF_FFFF_FFFF. Set RegWrite=0 and read port1=5, port2=6 → 64'h1234 / 64'hFFFF_FFFF_FFFF_FFFF. Confirm X4 and X7 still read 0.
- Zero register: with RegWrite=1, write X31 ← 64'hDEAD. Read X31 on both ports in the same cycle and the next → 0 both times. Confirm no other register changed.
- Bypass: X9 holds 64'h10. In one cycle drive RegWrite=1, WriteRegister=9, WriteData=64'h20, ReadRegister1=9. ReadData1 = 64'h20 before the edge and after it. With RegWrite=0 and the same address, ReadData1 = 64'h10 before the edge.
- Dual port same address: X3 = 64'h77. Read port1=port2=3 → both 64'h77. Repeat with a concurrent write X3 ← 64'h88 → both 64'h88.
- Write blocked in reset: hold reset=0, RegWrite=1, write X2 ← 64'h55 across 3 edges. Release reset with RegWrite=0 → X2 reads 0.
